// File: rtl/bus_xfer_ctrl_pkg.sv
// Shared definitions for the nibble-wide bus transfer controller:
// state encoding and bus nibble width.
package bus_xfer_ctrl_pkg;

    localparam int NIB_W = 4;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_WR_HI = 3'd2;
    localparam logic [2:0] S_WR_LO = 3'd3;
    localparam logic [2:0] S_TURN  = 3'd4;
    localparam logic [2:0] S_RD_HI = 3'd5;
    localparam logic [2:0] S_RD_LO = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    typedef enum logic [2:0] {
        IDLE  = S_IDLE,
        ADDR  = S_ADDR,
        WR_HI = S_WR_HI,
        WR_LO = S_WR_LO,
        TURN  = S_TURN,
        RD_HI = S_RD_HI,
        RD_LO = S_RD_LO,
        DONE  = S_DONE
    } state_t;

endpackage

// File: rtl/bus_xfer_ctrl.sv
// Byte transfer controller over a 4-bit multiplexed bidirectional bus.
// A request is split into an address nibble followed by two data nibbles
// (high first). Reads insert TURN_CYCLES released cycles so the far end
// can take over the bus before the first sample.
//
// Request handshake: req_ready is high only in IDLE; a request is taken on
// the rising edge where req_valid && req_ready. The request fields are
// latched on that edge, so the requester may change them afterwards.
// req_valid while busy is ignored (nothing is queued). rsp_valid is a
// single-cycle completion pulse with no back-pressure.
module bus_xfer_ctrl
    import bus_xfer_ctrl_pkg::*;
#(
    parameter int TURN_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [NIB_W-1:0]   req_addr,
    input  logic [2*NIB_W-1:0] req_wdata,
    output logic               rsp_valid,
    output logic [2*NIB_W-1:0] rsp_rdata,
    output logic               bus_we,
    output logic [NIB_W-1:0]   bus_dout,
    input  logic [NIB_W-1:0]   bus_din,
    output logic               bus_astb,
    output logic [2:0]         dbg_state_o
);

    state_t               state_q, state_d;
    logic                 wr_q, wr_d;
    logic [NIB_W-1:0]     addr_q, addr_d;
    logic [2*NIB_W-1:0]   wdata_q, wdata_d;
    logic [2*NIB_W-1:0]   rdata_q, rdata_d;
    logic [2:0]           turn_cnt_q, turn_cnt_d;

    // State, latched request and read-data registers; reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            turn_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            turn_cnt_q <= turn_cnt_d;
        end
    end

    // Next-state logic, request capture, turnaround count and read capture.
    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        turn_cnt_d = turn_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (wr_q) begin
                    state_d = WR_HI;
                end else begin
                    // Counter holds the number of TURN cycles still to go after this one.
                    turn_cnt_d = 3'(TURN_CYCLES - 1);
                    state_d    = TURN;
                end
            end
            WR_HI: state_d = WR_LO;
            WR_LO: state_d = DONE;
            TURN: begin
                if (turn_cnt_q == 3'd0) begin
                    state_d = RD_HI;
                end else begin
                    turn_cnt_d = turn_cnt_q - 3'd1;
                end
            end
            RD_HI: begin
                rdata_d[2*NIB_W-1:NIB_W] = bus_din;
                state_d = RD_LO;
            end
            RD_LO: begin
                rdata_d[NIB_W-1:0] = bus_din;
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus and handshake outputs decoded from the state register and latched fields only.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        bus_we    = 1'b1;
        bus_dout  = '0;
        bus_astb  = 1'b0;
        unique case (state_q)
            IDLE:  req_ready = 1'b1;
            ADDR: begin
                bus_we   = 1'b0;
                bus_dout = addr_q;
                bus_astb = 1'b1;
            end
            WR_HI: begin
                bus_we   = 1'b0;
                bus_dout = wdata_q[2*NIB_W-1:NIB_W];
            end
            WR_LO: begin
                bus_we   = 1'b0;
                bus_dout = wdata_q[NIB_W-1:0];
            end
            DONE:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign rsp_rdata   = rdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed bench for bus_xfer_ctrl: a vector table of complete transactions
// checked cycle by cycle, plus hand sequences for back-to-back requests,
// reset mid-transfer and a longer turnaround.
module tb_bus_xfer_ctrl;
    import bus_xfer_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_write;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic [3:0] bus_din;

    logic       ready1, rv1, we1, astb1;
    logic [7:0] rdata1;
    logic [3:0] dout1;
    logic [2:0] dbg1;
    logic       ready3, rv3, we3, astb3;
    logic [7:0] rdata3;
    logic [3:0] dout3;
    logic [2:0] dbg3;

    logic       sel3;
    logic       o_ready, o_rv, o_we, o_astb;
    logic [7:0] o_rdata;
    logic [3:0] o_dout;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [3:0] din_hi;
        logic [3:0] din_lo;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    bus_xfer_ctrl #(.TURN_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(ready1), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv1), .rsp_rdata(rdata1),
        .bus_we(we1), .bus_dout(dout1), .bus_din(bus_din), .bus_astb(astb1),
        .dbg_state_o(dbg1)
    );

    bus_xfer_ctrl #(.TURN_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(ready3), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv3), .rsp_rdata(rdata3),
        .bus_we(we3), .bus_dout(dout3), .bus_din(bus_din), .bus_astb(astb3),
        .dbg_state_o(dbg3)
    );

    // Observe either instance through one set of names.
    always_comb begin
        o_ready = sel3 ? ready3 : ready1;
        o_rv    = sel3 ? rv3    : rv1;
        o_we    = sel3 ? we3    : we1;
        o_astb  = sel3 ? astb3  : astb1;
        o_rdata = sel3 ? rdata3 : rdata1;
        o_dout  = sel3 ? dout3  : dout1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // One full transaction; expected bus activity per cycle comes from the
    // cycle index: 1=ADDR, then write data nibbles or TURN cycles + reads, last=DONE.
    task automatic run_xfer(input vec_t v, input int turn);
        int lat;
        logic       e_we, e_astb, e_rv;
        logic [3:0] e_dout;
        lat = v.wr ? 4 : 4 + turn;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        #1 check("ready_in_idle", 32'(o_ready), 32'd1);
        @(posedge clk);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            req_valid = (c < lat);
            req_write = 1'($urandom_range(0, 1));
            req_addr  = 4'($urandom_range(0, 15));
            req_wdata = 8'($urandom_range(0, 255));
            bus_din   = 4'($urandom_range(0, 15));
            if (!v.wr && c == turn + 2) bus_din = v.din_hi;
            if (!v.wr && c == turn + 3) bus_din = v.din_lo;
            e_we = 1'b1; e_dout = 4'h0; e_astb = 1'b0; e_rv = (c == lat);
            if (c == 1) begin
                e_we = 1'b0; e_dout = v.addr; e_astb = 1'b1;
            end else if (v.wr && c == 2) begin
                e_we = 1'b0; e_dout = v.wdata[7:4];
            end else if (v.wr && c == 3) begin
                e_we = 1'b0; e_dout = v.wdata[3:0];
            end
            #1 check("bus_cycle", 32'({o_we, o_dout, o_astb, o_rv, o_ready}),
                     32'({e_we, e_dout, e_astb, e_rv, 1'b0}));
            if (c == lat) check("rsp_rdata", 32'(o_rdata), 32'(v.exp_rdata));
        end
        @(posedge clk);
        req_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int acc_cycle[$];
        int exp_q[$];
        int t, pulses, exp_pulses;
        logic nxt_wr;
        vec_t v3;

        sel3      = 1'b0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 4'h0;
        req_wdata = 8'h00;
        bus_din   = 4'h0;

        vecs[0] = '{wr: 1'b1, addr: 4'hA, wdata: 8'h5C, din_hi: 4'h0, din_lo: 4'h0, exp_rdata: 8'h00};
        vecs[1] = '{wr: 1'b0, addr: 4'h3, wdata: 8'h00, din_hi: 4'h9, din_lo: 4'hE, exp_rdata: 8'h9E};
        vecs[2] = '{wr: 1'b1, addr: 4'h1, wdata: 8'hFF, din_hi: 4'h0, din_lo: 4'h0, exp_rdata: 8'h9E};
        vecs[3] = '{wr: 1'b0, addr: 4'hF, wdata: 8'hA5, din_hi: 4'h0, din_lo: 4'h1, exp_rdata: 8'h01};
        vecs[4] = '{wr: 1'b0, addr: 4'h0, wdata: 8'h00, din_hi: 4'hF, din_lo: 4'hF, exp_rdata: 8'hFF};
        vecs[5] = '{wr: 1'b1, addr: 4'h0, wdata: 8'h00, din_hi: 4'h0, din_lo: 4'h0, exp_rdata: 8'hFF};

        // Reset state
        #2;
        check("reset_outputs", 32'({we1, dout1, astb1, rv1, ready1}), 32'({1'b1, 4'h0, 1'b0, 1'b0, 1'b1}));
        check("reset_rdata", 32'(rdata1), 32'h0);
        check("reset_state", 32'(dbg1), 32'(S_IDLE));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("ready_after_reset", 32'(ready1), 32'd1);

        // Vector table
        foreach (vecs[i]) run_xfer(vecs[i], 1);

        // req_valid held high, alternating write/read: accepts spaced 5 (write) / 6 (read) cycles
        exp_q = {};
        t = 0; nxt_wr = 1'b1; exp_pulses = 0;
        while (t < 40) begin
            exp_q.push_back(t);
            if (t + (nxt_wr ? 4 : 5) < 40) exp_pulses++;
            t = t + (nxt_wr ? 5 : 6);
            nxt_wr = ~nxt_wr;
        end
        acc_cycle = {};
        pulses = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h7; req_wdata = 8'h42; bus_din = 4'h0;
        for (int c = 0; c < 40; c++) begin
            logic acc;
            #1;
            acc = ready1;
            if (acc) acc_cycle.push_back(c);
            if (rv1) pulses++;
            @(posedge clk);
            #1 if (acc) req_write = ~req_write;
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("b2b_accept_count", 32'(acc_cycle.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < acc_cycle.size(); k++)
            check("b2b_accept_cycle", 32'(acc_cycle[k]), 32'(exp_q[k]));
        check("b2b_rsp_pulses", 32'(pulses), 32'(exp_pulses));
        repeat (10) @(negedge clk);

        // Reset asserted during WR_HI
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h6; req_wdata = 8'h3D;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1 check("wr_hi_before_reset", 32'({we1, dout1}), 32'({1'b0, 4'h3}));
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("reset_mid_bus", 32'({we1, dout1, astb1, rv1}), 32'({1'b1, 4'h0, 1'b0, 1'b0}));
        check("reset_mid_ready", 32'(ready1), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1 check("reset_no_rsp", 32'(rv1), 32'd0);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1 check("release_no_rsp_idle", 32'({rv1, ready1}), 32'({1'b0, 1'b1}));
            @(negedge clk);
        end
        run_xfer('{wr: 1'b1, addr: 4'h2, wdata: 8'hB4, din_hi: 4'h0, din_lo: 4'h0, exp_rdata: 8'h00}, 1);
        run_xfer('{wr: 1'b0, addr: 4'hC, wdata: 8'h00, din_hi: 4'h6, din_lo: 4'h0, exp_rdata: 8'h60}, 1);

        // TURN_CYCLES=3 instance: three released cycles before RD_HI, latency 7
        pulse_reset();
        sel3 = 1'b1;
        v3 = '{wr: 1'b0, addr: 4'h5, wdata: 8'h00, din_hi: 4'h4, din_lo: 4'hB, exp_rdata: 8'h4B};
        run_xfer(v3, 3);
        run_xfer('{wr: 1'b1, addr: 4'h9, wdata: 8'h81, din_hi: 4'h0, din_lo: 4'h0, exp_rdata: 8'h4B}, 3);
        sel3 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bus_xfer_ctrl.md
BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

Interface
REQ-001 Parameter TURN_CYCLES, default 1, number of bus-release cycles between the address phase and the read sampling (legal range 1..4).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req_valid  input  1  transaction request present.
REQ-005 req_ready  output  1  controller can accept a request this cycle.
REQ-006 req_write  input  1  1 = write transaction, 0 = read transaction.
REQ-007 req_addr  input  4  target address nibble.
REQ-008 req_wdata  input  8  write data byte.
REQ-009 rsp_valid  output  1  one-cycle pulse: transaction complete.
REQ-010 rsp_rdata  output  8  byte read by the last completed read.
REQ-011 bus_we  output  1  bus port write-enable: 1 = bidirectional bus released (high-Z), 0 = bus driven from bus_dout.
REQ-012 bus_dout  output  4  nibble presented to the bus port for driving.
REQ-013 bus_din  input  4  nibble sampled from the bus port.
REQ-014 bus_astb  output  1  high during the address phase only.

Function
REQ-015 States: IDLE, ADDR, WR_HI, WR_LO, TURN, RD_HI, RD_LO, DONE.
REQ-016 req_ready shall be 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1 on a clock edge.
REQ-017 On acceptance, req_write, req_addr and req_wdata shall be latched; later changes on those inputs shall not affect the transaction.
REQ-018 IDLE -> ADDR on acceptance; ADDR -> WR_HI (write) or TURN (read).
REQ-019 Write path: WR_HI -> WR_LO -> DONE, each one cycle.
REQ-020 Read path: TURN lasts exactly TURN_CYCLES cycles, counted by an internal down-counter; TURN -> RD_HI -> RD_LO -> DONE.
REQ-021 DONE lasts one cycle, then IDLE; rsp_valid is 1 exactly in DONE.
REQ-022 ADDR: bus_we=0, bus_dout=latched addr, bus_astb=1.
REQ-023 WR_HI: bus_we=0, bus_dout=wdata[7:4]; WR_LO: bus_we=0, bus_dout=wdata[3:0].
REQ-024 IDLE, TURN, RD_HI, RD_LO, DONE: bus_we=1, bus_dout=0, bus_astb=0.
REQ-025 bus_din shall be captured into rsp_rdata[7:4] at the edge ending RD_HI and into rsp_rdata[3:0] at the edge ending RD_LO.
REQ-026 Write transactions shall leave rsp_rdata unchanged.
REQ-027 Latency from accepting edge to rsp_valid: write 4 cycles, read 4+TURN_CYCLES cycles.
REQ-028 req_valid while not in IDLE shall be ignored, with no state change and no queuing.
REQ-029 Back-to-back: earliest next acceptance is the edge after DONE (one IDLE cycle minimum).
REQ-030 bus_we shall never change 1->0 without passing through IDLE, and must be 1 for at least TURN_CYCLES cycles before the first read sample (no bus contention).
REQ-031 All outputs shall be registered or decoded from the state register only; no combinational path from req_* to bus_*.

Reset
REQ-032 rst_n low shall immediately force state IDLE, bus_we=1, bus_dout=0, bus_astb=0, rsp_valid=0, rsp_rdata=0, turn counter=0, latched request fields=0.
REQ-033 Reset mid-transaction shall abort it with no rsp_valid pulse; after release, operation resumes from IDLE with req_ready=1 on the first cycle.

Structure
REQ-034 A shared package shall hold the state encoding (3-bit localparams) and the bus nibble width constant (4).
REQ-035 No sub-module is required; the bus port stage sits outside this block and connects to bus_we/bus_dout/bus_din.

Verification
REQ-036 Write addr=0xA, wdata=0x5C -> bus_dout sequence A,5,C with bus_we=0 for 3 cycles, bus_astb only on first; rsp_valid 4 cycles after accept.
REQ-037 Read addr=0x3, TURN_CYCLES=1, bus_din=0x9 in RD_HI and 0xE in RD_LO -> rsp_rdata=0x9E with rsp_valid 5 cycles after accept; bus_we=1 from TURN onward.
REQ-038 TURN_CYCLES=3 read -> exactly 3 released cycles before RD_HI; latency 7 cycles.
REQ-039 req_valid held high continuously with alternating write/read -> accepts spaced by one IDLE cycle; requests presented while busy not executed.
REQ-040 rst_n asserted during WR_HI -> same-instant bus_we=1, bus_dout=0; no rsp_valid; next request after release completes normally.
REQ-041 Write after read of 0x9E -> rsp_rdata stays 0x9E.
